// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared constants, width helper and one-hot type for the decoder
package decoder_pkg;

   localparam int DEF_SEL_W = 4;

   function automatic int onehot_width(input int sel_w);
      return 1 << sel_w;
   endfunction

   localparam int DEF_OUT_W = 1 << DEF_SEL_W;

   typedef logic [DEF_OUT_W-1:0] onehot_t;

endpackage

// File: rtl/decoder_onehot_core.sv
// rtl/decoder_onehot_core.sv - combinational binary to raw active-high one-hot decode
module decoder_onehot_core
   import decoder_pkg::*;
#(
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic [SEL_W-1:0]       select,
   output logic [(1<<SEL_W)-1:0]  onehot
);

   // OUT_W is exactly 2**SEL_W, so every select value maps to a real line.
   always_comb begin
      onehot         = '0;
      onehot[select] = 1'b1;
   end

endmodule

// File: rtl/decoder_onehot_reg.sv
// rtl/decoder_onehot_reg.sv - registered one-hot decoder with enable gating and output polarity
module decoder_onehot_reg
   import decoder_pkg::*;
#(
   parameter int SEL_W      = DEF_SEL_W,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [SEL_W-1:0]       select,
   output logic [(1<<SEL_W)-1:0]  d,
   output logic                   d_valid,
   output logic [SEL_W-1:0]       sel_q
);

   localparam int OUT_W = onehot_width(SEL_W);
   localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{ACTIVE_LOW}};

   logic [OUT_W-1:0] raw;
   logic [OUT_W-1:0] d_d;
   logic [OUT_W-1:0] d_q;
   logic             d_valid_q;

   decoder_onehot_core #(
      .SEL_W (SEL_W)
   ) u_core (
      .select (select),
      .onehot (raw)
   );

   // Polarity is folded in before the register so inversion costs no latency.
   always_comb begin
      d_d = POL_MASK;
      if (en) begin
         d_d = raw ^ POL_MASK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q       <= POL_MASK;
         d_valid_q <= 1'b0;
         sel_q     <= '0;
      end else begin
         d_q       <= d_d;
         d_valid_q <= en;
         if (en) begin
            sel_q <= select;
         end
      end
   end

   assign d       = d_q;
   assign d_valid = d_valid_q;

endmodule

// File: tb/tb_decoder_onehot_reg.sv
// tb/tb_decoder_onehot_reg.sv - directed and random checks of both output polarities
`timescale 1ns/1ps
module tb_decoder_onehot_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [3:0]  select = 4'h0;
   logic [15:0] d_hi, d_lo;
   logic        v_hi, v_lo;
   logic [3:0]  s_hi, s_lo;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] exp_d   = 16'h0000;
   logic        exp_v   = 1'b0;
   logic [3:0]  exp_sel = 4'h0;

   always #2.5 clk = ~clk;

   decoder_onehot_reg #(.SEL_W(4), .ACTIVE_LOW(1'b0)) u_hi (
      .clk(clk), .rst(rst), .en(en), .select(select),
      .d(d_hi), .d_valid(v_hi), .sel_q(s_hi)
   );

   decoder_onehot_reg #(.SEL_W(4), .ACTIVE_LOW(1'b1)) u_lo (
      .clk(clk), .rst(rst), .en(en), .select(select),
      .d(d_lo), .d_valid(v_lo), .sel_q(s_lo)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: the selected line is 2**select when enabled, nothing otherwise.
   task automatic step(input logic r, input logic e, input logic [3:0] s);
      rst = r; en = e; select = s;
      @(posedge clk);
      if (r) begin
         exp_d = 16'h0000; exp_v = 1'b0; exp_sel = 4'h0;
      end else if (e) begin
         exp_d = 16'(2 ** int'(s)); exp_v = 1'b1; exp_sel = s;
      end else begin
         exp_d = 16'h0000; exp_v = 1'b0;
      end
      #1;
      check("d_high",    {16'h0, d_hi}, {16'h0, exp_d});
      check("d_low",     {16'h0, d_lo}, {16'h0, ~exp_d});
      check("valid_hi",  {31'h0, v_hi}, {31'h0, exp_v});
      check("valid_lo",  {31'h0, v_lo}, {31'h0, exp_v});
      check("sel_q_hi",  {28'h0, s_hi}, {28'h0, exp_sel});
      check("sel_q_lo",  {28'h0, s_lo}, {28'h0, exp_sel});
      check("popcount",  32'($countones(d_hi)), {31'h0, exp_v});
   endtask

   initial begin
      // Reset held two cycles with enable and a select pending.
      step(1'b1, 1'b1, 4'h5);
      check("rst_d_hi", {16'h0, d_hi}, 32'h0000_0000);
      check("rst_d_lo", {16'h0, d_lo}, 32'h0000_FFFF);
      step(1'b1, 1'b1, 4'h5);

      // Full sweep, one select per cycle.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 4'(i));
         if (i == 0)  check("sweep_first", {16'h0, d_hi}, 32'h0000_0001);
         if (i == 15) check("sweep_last",  {16'h0, d_hi}, 32'h0000_8000);
      end

      // Enable gating with a fixed select.
      step(1'b0, 1'b1, 4'hA);
      check("gate_on",  {16'h0, d_hi}, 32'h0000_0400);
      step(1'b0, 1'b0, 4'hA);
      check("gate_off", {16'h0, d_hi}, 32'h0000_0000);
      check("gate_sel", {28'h0, s_hi}, 32'h0000_000A);
      step(1'b0, 1'b1, 4'hA);
      check("gate_on2", {16'h0, d_hi}, 32'h0000_0400);

      // Sweep interrupted by a one-cycle reset at select 7.
      for (int i = 0; i < 16; i++) begin
         step((i == 7), 1'b1, 4'(i));
         if (i == 7) check("mid_rst", {16'h0, d_hi}, 32'h0000_0000);
         if (i == 8) check("after_rst", {16'h0, d_hi}, 32'h0000_0100);
      end

      // Inverted polarity decode.
      step(1'b0, 1'b1, 4'h3);
      check("pol_low", {16'h0, d_lo}, 32'h0000_FFF7);

      // Random select/en/rst traffic.
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decoder_onehot_reg.md
Name: decoder_onehot_reg

Overview:
- Registered binary-to-one-hot decoder; default configuration is 4-bit select to 16-bit one-hot output.
- Used wherever a small index must drive per-line enables (register-file write strobes, chip selects, mux one-hot selects).
- Combinational decode followed by one output register stage. Output is glitch-free and timing-clean at the next stage.

Parameters:
- SEL_W, 4, width of the binary select input; legal range 1..6.
- OUT_W, 2**SEL_W, width of the one-hot output; derived, not overridable.
- ACTIVE_LOW, 0, 0 = selected line driven 1 with others 0; 1 = output inverted (selected line 0, others 1).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  decode enable; sampled each rising edge.
- select  input  SEL_W  binary index of the line to assert.
- d  output  OUT_W  registered one-hot decode of select.
- d_valid  output  1  registered; 1 when d holds a decode of an enabled select.
- sel_q  output  SEL_W  registered copy of the select that produced d.

Behaviour:
- All outputs are registered on the rising edge of clk; latency is exactly 1 cycle from select/en to d.
- Reset (rst=1 at a rising edge) is synchronous, has priority over everything, and is applied at that edge:
  - d goes to all-inactive: 0 when ACTIVE_LOW=0, all-ones when ACTIVE_LOW=1.
  - d_valid=0 and sel_q=0.
- Decode when rst=0 and en=1:
  - d[i] is active if and only if i == select; all other bits are inactive.
  - d_valid=1 and sel_q=select.
  - Exactly one bit of d is active; this popcount invariant holds in every enabled cycle.
- Idle when rst=0 and en=0:
  - d goes all-inactive and d_valid=0.
  - sel_q holds its previous value.
- Select changes every cycle: each value decodes independently with no hold-over; back-to-back selects give back-to-back one-hot outputs.
- Boundaries:
  - select=0 asserts d[0].
  - select=OUT_W-1 asserts d[OUT_W-1] (bit 15 at default).
  - No out-of-range select exists because OUT_W = 2**SEL_W.
- X or Z on select while en=1 is a bench error. Simulation assertion: d must be one-hot whenever d_valid=1.
- Reset asserted mid-stream: outputs clear on that same edge. The first decode after reset deasserts appears one cycle after the first enabled edge.
- ACTIVE_LOW is applied at the register input, so the polarity inversion adds no extra latency.

Decomposition:
- Shared package decoder_pkg holds:
  - the default SEL_W constant (4);
  - a function onehot_width(sel_w) returning 2**sel_w;
  - a typedef for the default 16-bit one-hot vector.
- One natural combinational sub-module, decoder_onehot_core (select -> raw one-hot, no clock). The top adds the enable gating, polarity, and registers.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, select=4'h5 -> d=16'h0000, d_valid=0, sel_q=0 on every edge while reset is held.
- Sweep: en=1, select stepped 4'h0..4'hF one per cycle (5 ns each) -> one cycle later d = 16'h0001, 16'h0002, 16'h0004 ... 16'h8000 in order; d_valid=1 throughout.
- Enable gating: select=4'hA, en toggles 1,0,1 -> d = 16'h0400, 16'h0000, 16'h0400; d_valid = 1,0,1; sel_q stays 4'hA.
- Mid-stream reset: during the sweep, rst=1 for one cycle at select=4'h7 -> d=16'h0000 that cycle; the next enabled select=4'h8 gives d=16'h0100 one cycle later.
- Polarity: ACTIVE_LOW=1 instance, select=4'h3, en=1 -> d=16'hFFF7; in reset d=16'hFFFF.
- Invariant: 1000 random select/en/rst cycles -> the popcount of the active bits of d equals d_valid in every cycle, and d matches a 1-cycle-delayed reference model.
